// File: rtl/elastic_pipe.sv
// -----------------------------------------------------------------------------
// elastic_pipe
//
// Parametrised chain of pipeline registers with a valid/ready handshake on both
// ends. It replaces a run of fixed inter-stage latches (IF/ID, ID/EX, ...). Any
// hazard or branch logic steers it only through the handshake and flush.
//
// Each stage k (0 = input side, DEPTH-1 = output side) holds a valid bit and a
// payload. A valid entry moves forward whenever the slot ahead is empty or is
// itself moving. Bubbles therefore collapse even while the output is stalled.
//
// Optional feature (macro ELASTIC_PIPE_SKID_EN):
//   This macro adds a one-entry skid register behind the last stage. With it,
//   in_ready_o and every internal advance depend only on registered state, so
//   there is no combinational path from out_ready_i to in_ready_o. Capacity
//   becomes DEPTH+1. Unstalled latency and throughput do not change.
//
// Parameters:
//   WIDTH  payload bits per stage
//   DEPTH  number of register stages (1..16)
//   CNT_W  width of occupancy_o (derived, leave at default)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   start_i      run enable; low freezes all state
//   flush_i      drop every held entry on the next edge (overrides start_i)
//   in_valid_i   upstream presents a payload
//   in_ready_o   chain accepts a payload this cycle
//   in_data_i    upstream payload
//   out_valid_o  oldest entry is available at the output
//   out_ready_i  downstream consumes this cycle
//   out_data_o   output payload (holds its last value when empty)
//   occupancy_o  registered count of valid entries held
// -----------------------------------------------------------------------------
module elastic_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 2)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] occupancy_o
);

  localparam int LAST = DEPTH - 1;

  // Stage state
  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CNT_W-1:0] r_occ;

  // Per-cycle control
  logic             w_run;
  logic             w_acc;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_fill;
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] w_src [DEPTH];
  logic [CNT_W-1:0] w_occ_nxt;

`ifdef ELASTIC_PIPE_SKID_EN
  logic             r_skid_v;
  logic [WIDTH-1:0] r_skid_d;
  logic             w_skid_v_nxt;
  logic             w_skid_load;
`endif

  // The chain only moves when it is enabled and no flush is pending.
  assign w_run = start_i & ~flush_i;

`ifdef ELASTIC_PIPE_SKID_EN
  // The skid entry is always older than the last stage, so it is presented first.
  assign out_valid_o = w_run & (r_skid_v | r_v[LAST]);
  assign out_data_o  = r_skid_v ? r_skid_d : r_d[LAST];
`else
  assign out_valid_o = w_run & r_v[LAST];
  assign out_data_o  = r_d[LAST];
`endif

  // Stage 0 can take a new payload when it is empty or its entry moves on.
  // The rst_i term keeps the handshake closed while reset is held.
  assign in_ready_o  = rst_i & w_run & (~r_v[0] | w_adv[0]);
  assign w_acc       = in_valid_i & in_ready_o;
  assign occupancy_o = r_occ;

  // Advance chain, computed from the output side back to the input side
  always_comb begin
    w_adv = {DEPTH{1'b0}};
`ifdef ELASTIC_PIPE_SKID_EN
    // The last stage empties whenever the skid slot is free. Its entry is
    // either consumed directly or parked in the skid slot. This uses only
    // registered state, which is what breaks the out_ready_i ripple.
    w_adv[LAST] = w_run & r_v[LAST] & ~r_skid_v;
`else
    w_adv[LAST] = out_valid_o & out_ready_i;
`endif
    for (int k = DEPTH - 2; k >= 0; k--) begin
      w_adv[k] = w_run & r_v[k] & (~r_v[k+1] | w_adv[k+1]);
    end
  end

  // Load enables, data sources and next valid vector for every stage
  always_comb begin
    w_fill    = {DEPTH{1'b0}};
    w_v_nxt   = {DEPTH{1'b0}};
    w_fill[0] = w_acc;
    w_src[0]  = in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      w_fill[k] = w_adv[k-1];
      w_src[k]  = r_d[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (flush_i) begin
        w_v_nxt[k] = 1'b0;
      end else begin
        w_v_nxt[k] = (r_v[k] & ~w_adv[k]) | w_fill[k];
      end
    end
  end

`ifdef ELASTIC_PIPE_SKID_EN
  // Skid slot next state: it is captured only when the last stage leaves
  // unconsumed, and it is released when it is consumed.
  always_comb begin
    w_skid_load = w_adv[LAST] & ~out_ready_i;
    if (flush_i) begin
      w_skid_v_nxt = 1'b0;
    end else if (r_skid_v) begin
      w_skid_v_nxt = ~(out_valid_o & out_ready_i);
    end else begin
      w_skid_v_nxt = w_skid_load;
    end
  end
`endif

  // Population count of the next valid state, registered as occupancy
  always_comb begin
    w_occ_nxt = {CNT_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      w_occ_nxt = w_occ_nxt + CNT_W'(w_v_nxt[k]);
    end
`ifdef ELASTIC_PIPE_SKID_EN
    w_occ_nxt = w_occ_nxt + CNT_W'(w_skid_v_nxt);
`endif
  end

  // State registers; data moves only with its valid, and flush leaves data intact
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_v   <= {DEPTH{1'b0}};
      r_occ <= {CNT_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= {WIDTH{1'b0}};
      end
`ifdef ELASTIC_PIPE_SKID_EN
      r_skid_v <= 1'b0;
      r_skid_d <= {WIDTH{1'b0}};
`endif
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
      for (int k = 0; k < DEPTH; k++) begin
        if (w_fill[k]) begin
          r_d[k] <= w_src[k];
        end
      end
`ifdef ELASTIC_PIPE_SKID_EN
      r_skid_v <= w_skid_v_nxt;
      if (w_skid_load) begin
        r_skid_d <= r_d[LAST];
      end
`endif
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
module tb_elastic_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 2);
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  localparam int CAP = DEPTH + SKID;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;
  logic [CNT_W-1:0] occupancy_o;

  always #5 clk_i = ~clk_i;

  elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of held payloads. Each payload has a
  // distance from the input (0 = just accepted, DEPTH-1 = output stage,
  // DEPTH = skid slot). The n-th oldest entry can never be closer to the
  // output than its rank allows. Otherwise every entry steps forward once
  // per enabled cycle.
  logic [31:0] mq_d[$];
  int          mq_p[$];
  int          m_np[$];
  logic        m_in_ready;
  logic        m_out_valid;
  logic        m_pop;
  logic [31:0] m_out_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit run;
    bit skid_full;
    int n;
    int cap;
    int np;
    run = start_i && !flush_i;
    n = mq_p.size();
    m_np.delete();
    m_out_valid = 1'b0;
    m_out_data  = 32'h0;
    skid_full   = 1'b0;
    if (n > 0) begin
      m_out_valid = run && (mq_p[0] >= DEPTH - 1);
      m_out_data  = mq_d[0];
      skid_full   = (SKID == 1) && (mq_p[0] == DEPTH);
    end
    m_pop = m_out_valid && out_ready_i;
    for (int j = (m_pop ? 1 : 0); j < n; j++) begin
      int i;
      i = j - (m_pop ? 1 : 0);
      if (SKID == 1) cap = skid_full ? (DEPTH - j) : (DEPTH - i);
      else           cap = DEPTH - 1 - i;
      np = mq_p[j];
      if (run) np = (mq_p[j] + 1 < cap) ? mq_p[j] + 1 : cap;
      m_np.push_back(np);
    end
    m_in_ready = run && ((m_np.size() == 0) || (m_np[m_np.size() - 1] > 0));
  endtask

  task automatic model_commit();
    if (flush_i) begin
      mq_d.delete();
      mq_p.delete();
    end else if (start_i) begin
      if (m_pop) void'(mq_d.pop_front());
      mq_p = m_np;
      if (in_valid_i && m_in_ready) begin
        mq_d.push_back(in_data_i);
        mq_p.push_back(0);
      end
    end
  endtask

  task automatic cyc_begin(input logic st, input logic fl, input logic iv,
                           input logic [31:0] id, input logic orr);
    start_i     = st;
    flush_i     = fl;
    in_valid_i  = iv;
    in_data_i   = id;
    out_ready_i = orr;
    #1;
    model_eval();
  endtask

  task automatic cyc_check_model();
    chk("m_in_ready",  32'(in_ready_o),  32'(m_in_ready));
    chk("m_out_valid", 32'(out_valid_o), 32'(m_out_valid));
    chk("m_occupancy", 32'(occupancy_o), 32'(mq_p.size()));
    if (m_out_valid) chk("m_out_data", out_data_o, m_out_data);
  endtask

  task automatic cyc_end();
    @(posedge clk_i);
    model_commit();
    #1;
  endtask

  typedef struct {
    logic        st;
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic        orr;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [31:0] e_occ;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int got;

    // Streaming 0x1..0x8 with no stall. Each payload appears 3 cycles after
    // it is accepted. Occupancy stays at 3 once the chain is primed, then it
    // drains to 0. The output keeps the last payload once empty.
    for (int c = 0; c < 12; c++) begin
      tbl[c].st   = 1'b1;
      tbl[c].fl   = 1'b0;
      tbl[c].iv   = (c < 8);
      tbl[c].id   = (c < 8) ? 32'(c + 1) : 32'h0;
      tbl[c].orr  = 1'b1;
      tbl[c].e_ir = 1'b1;
      tbl[c].e_ov = (c >= 3) && (c <= 10);
      tbl[c].e_od = (c < 3) ? 32'h0 : ((c <= 10) ? 32'(c - 2) : 32'h8);
      tbl[c].e_occ = (c < 3) ? 32'(c) : ((c <= 8) ? 32'd3 : 32'(11 - c));
    end

    rst_i = 1'b0; start_i = 1'b1; flush_i = 1'b0;
    in_valid_i = 1'b0; in_data_i = 32'h0; out_ready_i = 1'b1;
    #12;
    chk("rst_in_ready",  32'(in_ready_o),  32'h0);
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_occupancy", 32'(occupancy_o), 32'h0);
    chk("rst_out_data",  out_data_o,       32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    for (int c = 0; c < 12; c++) begin
      cyc_begin(tbl[c].st, tbl[c].fl, tbl[c].iv, tbl[c].id, tbl[c].orr);
      chk("tbl_in_ready",  32'(in_ready_o),  32'(tbl[c].e_ir));
      chk("tbl_out_valid", 32'(out_valid_o), 32'(tbl[c].e_ov));
      chk("tbl_out_data",  out_data_o,       tbl[c].e_od);
      chk("tbl_occupancy", 32'(occupancy_o), tbl[c].e_occ);
      cyc_end();
    end

    // Back-pressure: fill against a stalled output, then drain in order.
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      cyc_begin(1'b1, 1'b0, 1'b1, 32'h100 + 32'(acc), 1'b0);
      cyc_check_model();
      if (in_ready_o) begin
        acc++;
        cyc_end();
      end else begin
        cyc_end();
        break;
      end
    end
    chk("bp_accepts",   32'(acc),         32'(CAP));
    chk("bp_occupancy", 32'(occupancy_o), 32'(CAP));
    got = 0;
    for (int k = 0; k < CAP + 4; k++) begin
      cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc_check_model();
      if (out_valid_o) begin
        chk("bp_order", out_data_o, 32'h100 + 32'(got));
        got++;
      end
      cyc_end();
    end
    chk("bp_drained", 32'(got), 32'(CAP));

    // Bubble collapse: two payloads separated by a gap close up behind a stall.
    cyc_begin(1'b1, 1'b0, 1'b1, 32'hA, 1'b0); cyc_check_model(); cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); cyc_check_model(); cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); cyc_check_model(); cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b1, 32'hB, 1'b0); cyc_check_model(); cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); cyc_check_model(); cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); cyc_check_model();
    chk("bub_occupancy", 32'(occupancy_o), 32'h2);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("bub_first_valid", 32'(out_valid_o), 32'h1);
    chk("bub_first_data",  out_data_o,       32'hA);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("bub_second_valid", 32'(out_valid_o), 32'h1);
    chk("bub_second_data",  out_data_o,       32'hB);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("bub_empty_valid", 32'(out_valid_o), 32'h0);
    cyc_end();

    // Flush with three entries held and a payload offered during the flush.
    for (int k = 0; k < 3; k++) begin
      cyc_begin(1'b1, 1'b0, 1'b1, 32'h31 + 32'(k), 1'b0); cyc_check_model(); cyc_end();
    end
    cyc_begin(1'b1, 1'b1, 1'b1, 32'h77, 1'b1);
    chk("flush_in_ready",  32'(in_ready_o),  32'h0);
    chk("flush_out_valid", 32'(out_valid_o), 32'h0);
    cyc_end();
    chk("flush_occupancy", 32'(occupancy_o), 32'h0);
    for (int k = 0; k < DEPTH + 2; k++) begin
      cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("flush_no_capture", 32'(out_valid_o), 32'h0);
      cyc_end();
    end

    // Freeze with two entries held: nothing moves, then resume in order.
    cyc_begin(1'b1, 1'b0, 1'b1, 32'h41, 1'b0); cyc_check_model(); cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b1, 32'h42, 1'b0); cyc_check_model(); cyc_end();
    for (int k = 0; k < 5; k++) begin
      cyc_begin(1'b0, 1'b0, 1'b1, 32'h99, 1'b1);
      chk("frz_out_valid", 32'(out_valid_o), 32'h0);
      chk("frz_in_ready",  32'(in_ready_o),  32'h0);
      chk("frz_occupancy", 32'(occupancy_o), 32'h2);
      cyc_end();
    end
    got = 0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc_check_model();
      if (out_valid_o) begin
        chk("frz_order", out_data_o, 32'h41 + 32'(got));
        got++;
      end
      cyc_end();
    end
    chk("frz_drained", 32'(got), 32'h2);

    // Asynchronous reset between edges with three entries held.
    for (int k = 0; k < 3; k++) begin
      cyc_begin(1'b1, 1'b0, 1'b1, 32'h61 + 32'(k), 1'b0); cyc_check_model(); cyc_end();
    end
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid_o), 32'h0);
    chk("arst_occupancy", 32'(occupancy_o), 32'h0);
    chk("arst_in_ready",  32'(in_ready_o),  32'h0);
    mq_d.delete();
    mq_p.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cyc_begin(1'b1, 1'b0, 1'b1, 32'h55, 1'b1);
    cyc_check_model();
    chk("arst_accept", 32'(in_ready_o), 32'h1);
    cyc_end();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc_check_model();
      if (i < DEPTH) begin
        chk("arst_lat_early", 32'(out_valid_o), 32'h0);
      end else begin
        chk("arst_lat_valid", 32'(out_valid_o), 32'h1);
        chk("arst_lat_data",  out_data_o,       32'h55);
      end
      cyc_end();
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 800; k++) begin
      cyc_begin(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 9) < 6), $urandom(), ($urandom_range(0, 9) < 6));
      cyc_check_model();
      cyc_end();
    end
    for (int k = 0; k < CAP + 2; k++) begin
      cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc_check_model();
      cyc_end();
    end
    chk("final_empty", 32'(occupancy_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Parametrised pipeline-register chain with valid/ready handshake, stall back-pressure, flush and bubble collapse.
- Generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches of the 5-stage core.
- One instance replaces a run of inter-stage latches: configurable payload width and stage count.
- Hazard/branch logic drives it through handshake and flush, not through per-latch hacks.

Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 3, number of register stages (legal range 1..16).
- CNT_W, $clog2(DEPTH+2), width of occupancy_o (derived; do not override).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- start_i  in  1  run enable; low = freeze.
- flush_i  in  1  discard all held entries.
- in_valid_i  in  1  upstream has a payload.
- in_ready_o  out  1  chain accepts a payload this cycle.
- in_data_i  in  WIDTH  upstream payload.
- out_valid_o  out  1  last stage holds a payload.
- out_ready_i  in  1  downstream consumes this cycle.
- out_data_o  out  WIDTH  last-stage payload.
- occupancy_o  out  CNT_W  number of valid entries held.

Behaviour:
- Reset (rst_i=0, asynchronous): all stage valid bits 0, all stage data 0, occupancy_o=0, out_valid_o=0, out_data_o=0. in_ready_o=0 while reset is asserted.
- Stage k (0 = input side, DEPTH-1 = output side) holds v[k] and d[k].
- Output:
  - out_valid_o = v[DEPTH-1] & start_i & ~flush_i.
  - out_data_o = d[DEPTH-1].
- Advance rule:
  - adv[DEPTH-1] = out_valid_o & out_ready_i.
  - Stage k (k < DEPTH-1) moves forward when v[k] & (~v[k+1] | adv[k+1]).
  - This gives bubble collapse: a valid entry moves into an empty slot even while downstream stalls.
- Input acceptance:
  - in_ready_o = start_i & ~flush_i & (~v[0] | v[0] advances).
  - A transfer happens when in_valid_i & in_ready_o.
- Latency: accepted payload appears on out_data_o with out_valid_o=1 exactly DEPTH cycles after acceptance if never stalled.
- Throughput: 1 payload/cycle sustained when out_ready_i=1.
- Ordering: strict FIFO; no payload dropped or duplicated except by flush.
- Occupancy:
  - occupancy_o = popcount(v), registered.
  - Same-cycle accept and consume leaves it unchanged.
  - Max value DEPTH (DEPTH+1 with the skid option).
- Full: all v=1 and out_ready_i=0 → in_ready_o=0, all state held.
- Empty: out_valid_o=0; out_data_o holds its last value (not cleared).
- flush_i=1:
  - Next edge clears every v to 0; data regs are not cleared.
  - in_ready_o=0 and out_valid_o=0 during the flush cycle, so no transfer occurs.
  - Flush overrides start_i.
- start_i=0 (flush_i=0):
  - Full freeze: no state change, in_ready_o=0, out_valid_o=0.
  - Resuming restores exactly the prior contents.
- Reset mid-operation: immediate clear as above. First acceptance is possible on the first edge after rst_i rises with start_i=1.
- Combinational path: out_ready_i → in_ready_o ripples through DEPTH stages (removed by the optional feature).

Optional Feature:
- Macro: ELASTIC_PIPE_SKID_EN.
- Defined:
  - Adds a one-entry skid register behind stage DEPTH-1.
  - in_ready_o and all internal advances depend only on registered state; no out_ready_i → in_ready_o combinational path.
  - Capacity becomes DEPTH+1.
  - Unstalled latency stays DEPTH; sustained throughput stays 1/cycle.
  - Flush clears the skid valid too.
- Undefined: no skid entry; capacity DEPTH; behaviour as above.

Test Plan:
- Reset, then stream 8 payloads 0x1..0x8 with out_ready_i=1, DEPTH=3 → out_data_o emits 0x1..0x8 on consecutive cycles, the first 3 cycles after its acceptance; occupancy_o stays 3 once primed.
- Stream with out_ready_i=0 → in_ready_o drops after exactly 3 accepts (4 with SKID_EN); occupancy_o=3 (4). Raise out_ready_i → remaining payloads drain in order, none lost.
- Bubble collapse: accept 0xA, idle 2 cycles, accept 0xB while out_ready_i=0 → 0xA and 0xB occupy adjacent top stages; releasing out_ready_i → 0xA then 0xB on consecutive cycles.
- Assert flush_i for 1 cycle with 3 entries held and in_valid_i=1 → in_ready_o=0 and out_valid_o=0 that cycle; next cycle occupancy_o=0; payload presented during the flush is not captured.
- Drop start_i for 5 cycles mid-stream with 2 entries held → no output and no acceptance; occupancy_o stays 2; after start_i=1 the same 2 payloads emit in order.
- Pull rst_i low asynchronously between edges with 3 entries held → out_valid_o=0 and occupancy_o=0 immediately; after release, new payload 0x55 emerges DEPTH cycles after acceptance.
